// File: rtl/histogram_accumulator.sv
// Histogram of bin-index beats with saturating counts, bulk clear and read-and-clear streaming readout.
// Latency: accumulate read-modify-write retires 2 cycles after accept; readout beat 1 cycle after its read.
// Backpressure: none on the input (beats outside ACCUM are dropped); readout beats hold until rd_ready.
module histogram_accumulator #(
    parameter int WIDTH       = 16,
    parameter int WIDTH_CNT   = 4,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   data_in_vd,
    input  logic [WIDTH-1:0]       data_in,
    input  logic [WIDTH_CNT-1:0]   data_in_cnt,
    input  logic                   clear_req,
    input  logic                   readout_req,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_addr,
    output logic [COUNT_WIDTH-1:0] rd_data,
    output logic                   busy,
    output logic                   dropped,
    output logic                   saturated
);

    localparam int DEPTH = 1 << WIDTH;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        ACCUM   = 2'd1,
        DRAIN   = 2'd2,
        READOUT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]       clr_addr;
    logic                   drain_cnt;
    logic                   drain_to_clear;

    logic                   acc_fire;
    logic                   ro_issue;
    logic                   ro_hs;

    logic                   s1_vld;
    logic [WIDTH-1:0]       s1_addr;
    logic [WIDTH_CNT-1:0]   s1_cnt;
    logic                   s2_vld;
    logic [WIDTH-1:0]       s2_addr;
    logic [COUNT_WIDTH-1:0] s2_data;
    logic [COUNT_WIDTH:0]   sum_wide;

    logic                   ram_we;
    logic [WIDTH-1:0]       ram_waddr;
    logic [COUNT_WIDTH-1:0] ram_wdata;
    logic                   ram_re;
    logic [WIDTH-1:0]       ram_raddr;
    logic [COUNT_WIDTH-1:0] ram_q;
    logic [COUNT_WIDTH-1:0] mem [DEPTH];

    always_comb begin
        state_nxt = state;
        acc_fire  = 1'b0;
        ro_issue  = 1'b0;
        ro_hs     = 1'b0;
        case (state)
            CLEAR: begin
                if (clr_addr == '1) state_nxt = ACCUM;
            end
            ACCUM: begin
                acc_fire = data_in_vd;
                if (clear_req || readout_req) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (drain_cnt) state_nxt = drain_to_clear ? CLEAR : READOUT;
            end
            READOUT: begin
                // Each bin takes a read cycle then a presentation cycle, capping the rate at 1 beat per 2 cycles.
                if (!rd_valid) begin
                    ro_issue = 1'b1;
                end else if (rd_ready) begin
                    ro_hs = 1'b1;
                    if (rd_addr == '1) state_nxt = ACCUM;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= CLEAR;
        else      state <= state_nxt;
    end

    assign sum_wide = {1'b0, ram_q} + {{(COUNT_WIDTH + 1 - WIDTH_CNT){1'b0}}, s1_cnt};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clr_addr       <= '0;
            drain_cnt      <= 1'b0;
            drain_to_clear <= 1'b0;
            rd_valid       <= 1'b0;
            rd_addr        <= '0;
            dropped        <= 1'b0;
            saturated      <= 1'b0;
            s1_vld         <= 1'b0;
            s1_addr        <= '0;
            s1_cnt         <= '0;
            s2_vld         <= 1'b0;
            s2_addr        <= '0;
            s2_data        <= '0;
        end else begin
            dropped   <= data_in_vd && (state != ACCUM);
            clr_addr  <= (state == CLEAR) ? clr_addr + 1'b1 : '0;
            drain_cnt <= (state == DRAIN) && !drain_cnt;
            if (state == ACCUM && (clear_req || readout_req)) drain_to_clear <= clear_req;

            if (ro_issue) begin
                rd_valid <= 1'b1;
            end else if (ro_hs) begin
                rd_valid <= 1'b0;
                rd_addr  <= rd_addr + 1'b1;
            end

            s1_vld  <= acc_fire;
            s1_addr <= data_in;
            s1_cnt  <= data_in_cnt;
            s2_vld  <= s1_vld;
            s2_addr <= s1_addr;
            s2_data <= sum_wide[COUNT_WIDTH] ? '1 : sum_wide[COUNT_WIDTH-1:0];
            if (s1_vld && sum_wide[COUNT_WIDTH]) saturated <= 1'b1;
        end
    end

    // Write sources never overlap: pipeline writes only retire in ACCUM/DRAIN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = s2_addr;
        ram_wdata = s2_data;
        if (s2_vld) begin
            ram_we = 1'b1;
        end else if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end else if (ro_hs) begin
            ram_we    = 1'b1;
            ram_waddr = rd_addr;
            ram_wdata = '0;
        end
    end

    assign ram_re    = acc_fire | ro_issue;
    assign ram_raddr = ro_issue ? rd_addr : data_in;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_q <= mem[ram_raddr];
    end

    // ram_q is not re-read while a beat is stalled, so the presented count stays stable.
    assign rd_data = rd_valid ? ram_q : '0;
    assign busy    = (state != ACCUM);

endmodule
